// File: rtl/fixed_nn_pkg.sv
// rtl/fixed_nn_pkg.sv - shared state type, width helpers and result clipping for the integer layer datapath
package fixed_nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_e;

  // Common width that accumulators are sign-extended to before clipping.
  localparam int CLIP_W = 64;

  function automatic int acc_width(input int bits, input int length);
    return 2 * bits + $clog2(length);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers keep the low BITS of the result; with sat clear that is plain wrap.
  function automatic logic signed [CLIP_W-1:0] clip_acc(
    input logic signed [CLIP_W-1:0] acc,
    input int                       bits,
    input bit                       sat
  );
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sat && (acc > hi)) return hi;
    if (sat && (acc < lo)) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/fixed_integer_row_mac.sv
// rtl/fixed_integer_row_mac.sv - one matrix row: MULTS signed multipliers, beat adder and accumulator
module fixed_integer_row_mac #(
  parameter int BITS     = 16,
  parameter int MULTS    = 2,
  parameter int ACC_BITS = 36
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              beat_i,
  input  logic                              first_i,
  input  logic [MULTS-1:0][BITS-1:0]        w_i,
  input  logic [MULTS-1:0][BITS-1:0]        x_i,
  output logic signed [ACC_BITS-1:0]        acc_d_o
);

  logic signed [ACC_BITS-1:0] acc_q;
  logic signed [ACC_BITS-1:0] acc_d;
  logic signed [ACC_BITS-1:0] beat_sum;
  logic signed [2*BITS-1:0]   prod [MULTS];

  always_comb begin
    beat_sum = '0;
    for (int m = 0; m < MULTS; m++) begin
      prod[m]  = (2*BITS)'(signed'(w_i[m])) * (2*BITS)'(signed'(x_i[m]));
      beat_sum = beat_sum + ACC_BITS'(prod[m]);
    end
    // The first beat of a vector restarts the sum rather than adding to stale data.
    acc_d = first_i ? beat_sum : acc_q + beat_sum;
  end

  assign acc_d_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (beat_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fixed_integer_matrix_dot_vector.sv
// rtl/fixed_integer_matrix_dot_vector.sv - ROWS x LENGTH weight matrix times a vector streamed in MULTS-wide beats
// Define FIXED_SATURATE_EN to saturate results; otherwise they wrap to BITS.
module fixed_integer_matrix_dot_vector
  import fixed_nn_pkg::*;
#(
  parameter int BITS     = 16,
  parameter int LENGTH   = 10,
  parameter int MULTS    = 2,
  parameter int ROWS     = 4,
  parameter int ACC_BITS = acc_width(BITS, LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_w,
  input  logic [MULTS-1:0][BITS-1:0] w_in,
  output logic                       w_ready,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MULTS-1:0][BITS-1:0] x_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROWS-1:0][BITS-1:0]  c
);

  localparam int BEATS = LENGTH / MULTS;
  localparam int KW    = idx_width(BEATS);
  localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

`ifdef FIXED_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  generate
    if ((LENGTH % MULTS) != 0 || ROWS < 1) begin : g_bad_cfg
      $error("fixed_integer_matrix_dot_vector: LENGTH must be a multiple of MULTS and ROWS >= 1");
    end
  endgenerate

  state_e                     state_q;
  logic [KW-1:0]              k_q;
  logic                       out_valid_q;
  logic [ROWS-1:0][BITS-1:0]  c_q;
  logic [ROWS-1:0][BITS-1:0]  c_d;

  // Slot w_q[r][b] holds flat weights f = (r*BEATS+b)*MULTS + m.
  logic [MULTS-1:0][BITS-1:0] w_q    [ROWS][BEATS];
  logic [MULTS-1:0][BITS-1:0] w_prev [ROWS][BEATS];
  logic signed [ACC_BITS-1:0] acc_d  [ROWS];

  logic in_fire;
  logic w_fire;
  logic last_beat;

  assign w_ready   = (state_q == IDLE);
  assign in_ready  = !rst && (((state_q == IDLE) && !load_w) || (state_q == ACCUM));
  assign in_fire   = in_valid && in_ready;
  assign w_fire    = load_w && w_ready;
  assign last_beat = (k_q == LAST_K);

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_prev_r
      for (genvar b = 0; b < BEATS; b++) begin : g_prev_b
        if (b > 0) begin : g_in_row
          assign w_prev[r][b] = w_q[r][b-1];
        end else if (r > 0) begin : g_row_carry
          assign w_prev[r][b] = w_q[r-1][BEATS-1];
        end else begin : g_head
          assign w_prev[r][b] = w_in;
        end
      end
    end
  endgenerate

  // Weight store is deliberately left out of reset so a reset keeps the loaded layer.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int b = 0; b < BEATS; b++) begin
          w_q[r][b] <= w_prev[r][b];
        end
      end
    end
  end

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      fixed_integer_row_mac #(
        .BITS     (BITS),
        .MULTS    (MULTS),
        .ACC_BITS (ACC_BITS)
      ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .beat_i  (in_fire),
        .first_i (k_q == '0),
        .w_i     (w_q[r][k_q]),
        .x_i     (x_in),
        .acc_d_o (acc_d[r])
      );
    end
  endgenerate

  always_comb begin
    c_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      c_d[r] = BITS'(clip_acc(CLIP_W'(acc_d[r]), BITS, SAT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (in_fire) begin
            if (last_beat) begin
              state_q     <= OUTPUT;
              k_q         <= '0;
              out_valid_q <= 1'b1;
              c_q         <= c_d;
            end else begin
              state_q <= ACCUM;
              k_q     <= k_q + KW'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;

endmodule

// File: tb/tb_fixed_integer_matrix_dot_vector.sv
// tb/tb_fixed_integer_matrix_dot_vector.sv - directed self-checking bench for the matrix-vector layer stage
module tb_fixed_integer_matrix_dot_vector;

  localparam int BITS   = 8;
  localparam int LENGTH = 4;
  localparam int MULTS  = 2;
  localparam int ROWS   = 2;
  localparam int BEATS  = LENGTH / MULTS;
`ifdef FIXED_SATURATE_EN
  localparam int OVF = 127;
`else
  localparam int OVF = 64;
`endif

  typedef logic [MULTS-1:0][BITS-1:0] beat_t;
  typedef logic [ROWS-1:0][BITS-1:0]  res_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  load_w;
  beat_t w_in;
  logic  w_ready;
  logic  in_valid;
  logic  in_ready;
  beat_t x_in;
  logic  out_valid;
  logic  out_ready;
  res_t  c;

  int    checks = 0;
  int    errors = 0;
  int    transfers = 0;
  beat_t loaded_q[$];
  res_t  exp_q[$];
  res_t  held_c;
  bit    held = 1'b0;

  always #5 clk = ~clk;

  fixed_integer_matrix_dot_vector #(
    .BITS   (BITS),
    .LENGTH (LENGTH),
    .MULTS  (MULTS),
    .ROWS   (ROWS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_w    (load_w),
    .w_in      (w_in),
    .w_ready   (w_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int sval(input logic [BITS-1:0] v);
    logic signed [BITS-1:0] s;
    s = v;
    return int'(s);
  endfunction

  // The beat loaded j-th from last holds flat weights j*MULTS .. j*MULTS+MULTS-1.
  function automatic int weight(input int f);
    beat_t b;
    b = loaded_q[loaded_q.size() - 1 - f / MULTS];
    return sval(b[f % MULTS]);
  endfunction

  function automatic int limit(input int acc);
`ifdef FIXED_SATURATE_EN
    int hi;
    int lo;
    hi = (1 <<< (BITS - 1)) - 1;
    lo = -hi - 1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
`else
    logic [BITS-1:0] t;
    t = acc[BITS-1:0];
    return sval(t);
`endif
  endfunction

  function automatic res_t model_result(input int xval);
    res_t r;
    int   acc;
    r = '0;
    for (int row = 0; row < ROWS; row++) begin
      acc = 0;
      for (int i = 0; i < LENGTH; i++) acc += weight(row * LENGTH + i) * xval;
      acc = limit(acc);
      r[row] = acc[BITS-1:0];
    end
    return r;
  endfunction

  task automatic load_beat(input int a, input int b, input bit accept);
    @(negedge clk);
    load_w  = 1'b1;
    w_in[0] = a[BITS-1:0];
    w_in[1] = b[BITS-1:0];
    #1;
    check("w_ready", w_ready, int'(accept));
    if (accept) loaded_q.push_back(w_in);
    @(posedge clk);
    #1 load_w = 1'b0;
  endtask

  // mode: 0 plain, 1 load attempt after beat 0, 2 reset after beat 0, 3 load alongside first beat
  task automatic send_vector(input int xval, input int gap, input int mode);
    for (int bt = 0; bt < BEATS; bt++) begin
      if (bt == 0 && mode == 3) begin
        @(negedge clk);
        load_w   = 1'b1;
        w_in[0]  = 8'd1;
        w_in[1]  = 8'd2;
        in_valid = 1'b1;
        x_in[0]  = xval[BITS-1:0];
        x_in[1]  = xval[BITS-1:0];
        #1;
        check("simul_in_ready", in_ready, 0);
        check("simul_w_ready", w_ready, 1);
        loaded_q.push_back(w_in);
        @(posedge clk);
        #1 load_w = 1'b0;
      end
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      x_in[0]  = xval[BITS-1:0];
      x_in[1]  = xval[BITS-1:0];
      #1;
      check("in_ready_beat", in_ready, 1);
      check("out_valid_early", out_valid, 0);
      if (bt == BEATS - 1) exp_q.push_back(model_result(xval));
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (bt == 0 && mode == 1) load_beat(9, 9, 1'b0);
      if (bt == 0 && mode == 2) begin
        @(negedge clk);
        rst = 1'b1;
        #1 check("in_ready_rst", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    #1 check("latency_valid", out_valid, 1);
  endtask

  task automatic load_basic();
    load_beat(-1, -1, 1'b1);
    load_beat(-1, -1, 1'b1);
    load_beat(3, 4, 1'b1);
    load_beat(1, 2, 1'b1);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      check("in_ready_output", in_ready, 0);
      check("w_ready_output", w_ready, 0);
      check("pending_vectors", exp_q.size(), 1);
      if (held) begin
        for (int r = 0; r < ROWS; r++) check("c_stable", sval(c[r]), sval(held_c[r]));
      end
      if (exp_q.size() > 0) begin
        if (out_ready) begin
          for (int r = 0; r < ROWS; r++) check("c_row", sval(c[r]), sval(exp_q[0][r]));
          void'(exp_q.pop_front());
          transfers++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_c = c;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t m;
    int   t0;
    rst       = 1'b1;
    load_w    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w_in      = '0;
    x_in      = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", int'(c), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_w_ready", w_ready, 1);

    load_basic();
    m = model_result(1);
    check("pin_basic_r0", sval(m[0]), 10);
    check("pin_basic_r1", sval(m[1]), -4);
    send_vector(1, 0, 0);
    check("basic_c0", sval(c[0]), 10);
    check("basic_c1", sval(c[1]), -4);
    @(negedge clk);
    #1;
    check("basic_back_idle", out_valid, 0);
    check("basic_in_ready", in_ready, 1);

    out_ready = 1'b0;
    send_vector(1, 3, 0);
    check("gap_c0", sval(c[0]), 10);
    check("gap_c1", sval(c[1]), -4);
    repeat (5) @(negedge clk);
    t0 = transfers;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_single_transfer", transfers - t0, 1);
    check("bp_valid_dropped", out_valid, 0);

    for (int i = 0; i < 4; i++) load_beat(100, 100, 1'b1);
    m = model_result(100);
    check("pin_ovf", sval(m[0]), OVF);
    send_vector(100, 0, 0);
    check("ovf_c0", sval(c[0]), OVF);
    check("ovf_c1", sval(c[1]), OVF);

    load_basic();
    send_vector(1, 0, 1);
    check("midload_c0", sval(c[0]), 10);
    check("midload_c1", sval(c[1]), -4);

    send_vector(5, 0, 2);
    m = model_result(2);
    check("pin_rst_r0", sval(m[0]), 20);
    send_vector(2, 0, 0);
    check("rst_c0", sval(c[0]), 20);
    check("rst_c1", sval(c[1]), -8);

    send_vector(1, 0, 3);
    check("simul_c0", sval(c[0]), 6);
    check("simul_c1", sval(c[1]), 5);

    repeat (2) @(negedge clk);
    #1;
    check("transfers", transfers, 6);
    check("pending_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_integer_matrix_dot_vector.md
Name: fixed_integer_matrix_dot_vector

Overview:
- Multi-row successor to the single-row fixed-integer dot-product block.
- Holds a ROWS x LENGTH signed weight matrix and streams an input vector in MULTS-element beats.
- Computes all ROWS dot products in parallel and returns them with a valid/ready handshake.
- Used as a dense neural-network layer stage in the integer datapath.

Parameters:
- BITS, 16, signed two's-complement width of weights, inputs and outputs
- LENGTH, 10, vector length; must be a multiple of MULTS
- MULTS, 2, elements consumed per beat (multipliers per row)
- ROWS, 4, output channels (matrix rows)
- ACC_BITS, 2*BITS+$clog2(LENGTH), accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- load_w  in  1  weight shift-in strobe
- w_in  in  BITS x MULTS  weight words for one load beat
- w_ready  out  1  weight load accepted this cycle (IDLE and no partial vector)
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- x_in  in  BITS x MULTS  input vector elements for current beat
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results
- c  out  BITS x ROWS  result vector

Behaviour:
- Flat weight index f = r*LENGTH + i.
- Each accepted load beat (load_w & w_ready) shifts the store up by MULTS words and writes w_in[m] into f = m.
- The beat loaded j-th from last ends at f = j*MULTS+m. Host therefore loads highest f first.
- A full load takes ROWS*LENGTH/MULTS beats.
- Weight store is not reset; contents persist across rst.
- States: IDLE, ACCUM, OUTPUT.
- IDLE: in_ready = !load_w, w_ready = 1. load_w has priority over in_valid in the same cycle.
  - First accepted beat goes to ACCUM, or directly to OUTPUT if LENGTH == MULTS.
- ACCUM: in_ready = 1, w_ready = 0; load_w is ignored.
- Beat counter k runs 0..LENGTH/MULTS-1 and advances only on accepted beats. Gaps in in_valid are allowed.
- Per accepted beat: acc[r] += sum over m of W[r][k*MULTS+m] * x_in[m].
  - Beat k = 0 loads the accumulator instead of adding.
  - Products are full 2*BITS signed.
- Accepting beat k = LENGTH/MULTS-1 at cycle t:
  - c and out_valid are registered at t+1.
  - State goes to OUTPUT; k wraps to 0.
- c[r] = acc[r][BITS-1:0] (wrap truncation) unless the optional feature is enabled.
- OUTPUT: in_ready = 0, w_ready = 0.
  - c and out_valid are held stable until out_valid & out_ready, then IDLE next cycle.
  - Throughput is LENGTH/MULTS + 1 cycles per vector when out_ready is held high.
- Reset values: out_valid = 0, c = 0, in_ready = 0 during rst, state = IDLE, k = 0, acc = 0.
- rst mid-ACCUM or mid-OUTPUT discards the partial or pending result; weights are kept.
- Elaboration error if LENGTH % MULTS != 0 or ROWS < 1.

Optional Feature:
- Macro FIXED_SATURATE_EN.
- Defined: c[r] saturates acc[r] to [-2^(BITS-1), 2^(BITS-1)-1].
- Undefined: c[r] is plain low-BITS truncation (wrap).
- Handshake and latency are identical in both cases.

Decomposition:
- Package fixed_nn_pkg holds:
  - state enum typedef (IDLE/ACCUM/OUTPUT)
  - saturate/truncate function parameterised by BITS and ACC_BITS
  - shared width constant helpers
- One sub-module, fixed_integer_row_mac: one row's MULTS multipliers, adder tree and accumulator.
  - Instantiated ROWS times by generate.

Test Plan (BITS=8, LENGTH=4, MULTS=2, ROWS=2 unless stated):
- Basic layer:
  - Load beats (-1,-1), (-1,-1), (3,4), (1,2) so row0 = [1,2,3,4] and row1 = [-1,-1,-1,-1].
  - Send x = (1,1), (1,1) with out_ready = 1.
  - Expect c = {10, -4}, with out_valid one cycle after the second beat.
- Gapped input and back-pressure:
  - Same weights; x beats separated by 3 idle cycles; hold out_ready = 0 for 5 cycles.
  - Expect c stable, in_ready = 0 throughout OUTPUT, and a single transfer.
- Overflow:
  - All weights = 100, x = 100.
  - Expect c = 64 without FIXED_SATURATE_EN and c = 127 with it.
- Load during ACCUM:
  - Assert load_w after the first x beat.
  - Expect w_ready = 0, weights unchanged, and the result matching the basic-layer case.
- Reset mid-ACCUM:
  - Assert rst after the first beat, then send a full vector x = (2,2), (2,2).
  - Expect c = {20, -8}; the stale partial sum is discarded and weights are retained.
- Simultaneous load_w and in_valid in IDLE:
  - Expect the load accepted, in_ready = 0 that cycle, and the x beat accepted the next cycle.
